cache_ctrl_nway: RTL and testbench
==================================

Name: cache_ctrl_nway

Overview:
- Parametrised successor of the single-channel cache control FSM.
- Controls an N-way set-associative cache: victim choice (first-invalid, else per-set round-robin), burst line fill/evict, selectable write policy.
- Sits between the system request port, the tag/data arrays (which supply per-way hit/valid/dirty vectors) and RAM.
- Datapath muxes are external; this block drives only their selects and write enables.

Parameters:
- WAYS, 4, associativity, power of 2, ≥2
- SETS, 16, number of sets, power of 2
- BURST_LEN, 4, RAM beats per line, power of 2, ≥1
- WRITE_BACK, 1, 1 = write-back/write-allocate with dirty bits; 0 = write-through/no-write-allocate

Ports:
- clk  in  1  clock
- not_reset  in  1  reset: one clock domain; asynchronous, active-low
- sys_rd  in  1  read request, level, held until sys_ack
- sys_wr  in  1  write request, level, held until sys_ack
- set_idx  in  $clog2(SETS)  set of the current request, stable while request held
- hit_vec  in  WAYS  per-way tag match, valid-qualified
- valid_vec  in  WAYS  per-way valid of set_idx
- dirty_vec  in  WAYS  per-way dirty of set_idx (ignored when WRITE_BACK=0)
- ram_ack  in  1  one RAM beat accepted/returned this cycle
- ram_avalid  out  1  RAM transaction active
- ram_rnw  out  1  1 = read, 0 = write
- ram_addr_victim  out  1  1 = RAM address uses victim tag (evict), 0 = request tag
- beat_idx  out  $clog2(BURST_LEN) (min 1)  current beat within the line
- way_sel  out  $clog2(WAYS)  way addressed in the arrays
- data_src  out  1  0 = system data, 1 = RAM data
- data_we  out  1  write data array word
- tag_we  out  1  write tag, set valid, clear dirty for way_sel
- dirty_set  out  1  set dirty for way_sel
- sys_ack  out  1  request complete

Behaviour:
- All outputs are registered (Moore).
- Reset: state = IDLE, every output 0 except ram_rnw = 1; all round-robin pointers = 0.
- Reset mid-operation aborts immediately; no outstanding state is retained.
- Request valid only when sys_rd ^ sys_wr; both high or both low keeps IDLE.
- State sequence:
  - IDLE: on a valid request, latch rd/wr and set_idx, go to LOOKUP.
  - LOOKUP (1 cycle): the hit way is the lowest index set in hit_vec.
    - Read hit -> ACK.
    - Write hit -> WHIT.
    - Miss, write, WRITE_BACK=0 -> WTHRU (no allocate).
    - Other misses: victim = lowest invalid way, else rr_ptr[set]. If the victim is valid, dirty and WRITE_BACK=1 -> EVICT, else -> FILL.
  - WHIT (1 cycle): data_we = 1, data_src = 0, way_sel = hit way.
    - WRITE_BACK=1: dirty_set = 1, then ACK.
    - WRITE_BACK=0: go to WTHRU.
  - WTHRU: ram_avalid = 1, ram_rnw = 0, single beat; on ram_ack -> ACK.
  - EVICT: ram_avalid = 1, ram_rnw = 0, ram_addr_victim = 1. beat_idx increments on each ram_ack; on the ram_ack at beat BURST_LEN-1 -> FILL with beat_idx = 0.
  - FILL: ram_avalid = 1, ram_rnw = 1, data_src = 1. data_we pulses in each ram_ack cycle at beat_idx; on the last beat -> UPDATE.
  - UPDATE (1 cycle): ram_avalid = 0, tag_we = 1, rr_ptr[set] += 1 (mod WAYS), only if the victim came from the pointer. Then re-enter LOOKUP, which now hits.
  - ACK: sys_ack = 1, held until sys_rd and sys_wr are both 0, then IDLE with sys_ack = 0.
- ram_avalid stays high continuously across a burst, with no bubbles between beats. A ram_ack outside EVICT, FILL or WTHRU is ignored.
- Latency:
  - Read hit: ack asserted 2 cycles after the request is sampled.
  - Clean read miss: 2 + BURST_LEN ack cycles + 2.

Optional Feature:
CACHE_CTRL_STATS_EN
- Defined: adds outputs stat_hits, stat_misses and stat_evicts, 32 bits each.
  - stat_hits or stat_misses increments once per request, in LOOKUP on first entry only; the re-lookup after UPDATE is not counted.
  - stat_evicts increments on entry to EVICT.
  - Counters wrap at 2^32 and clear on reset.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package cache_ctrl_pkg: state encoding constants (IDLE, LOOKUP, WHIT, WTHRU, EVICT, FILL, UPDATE, ACK) and localparam width helpers.
- Sub-module cache_victim_sel: combinational priority encoding of hit and invalid ways plus the per-set rr_ptr register file.

Test Plan:
- Read hit, WAYS=4, hit_vec=0100 -> way_sel=2, sys_ack high 2 cycles after sys_rd; no ram_avalid.
- Clean read miss, valid_vec=1111, dirty_vec=0000, rr_ptr=1, BURST_LEN=4 -> FILL of 4 beats into way 1, then tag_we, then re-LOOKUP hits, then ack; rr_ptr becomes 2.
- Dirty miss with WRITE_BACK=1, victim dirty -> EVICT with ram_rnw=0, ram_addr_victim=1 for 4 acks, then FILL for 4 acks, with ram_avalid never dropping between the two phases.
- WRITE_BACK=0 write miss -> single RAM write beat, no tag_we, ack. Write hit -> data_we, then RAM write, then ack.
- sys_rd=sys_wr=1 -> remains IDLE, no outputs asserted.
- not_reset pulsed low in FILL beat 2 -> all outputs at reset values immediately; the next request starts clean.

Source files
------------

// File: rtl/cache_ctrl_pkg.sv
// Shared state encoding and width helpers for the N-way cache controller.
package cache_ctrl_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOOKUP = 3'd1;
    localparam logic [2:0] ST_WHIT   = 3'd2;
    localparam logic [2:0] ST_WTHRU  = 3'd3;
    localparam logic [2:0] ST_EVICT  = 3'd4;
    localparam logic [2:0] ST_FILL   = 3'd5;
    localparam logic [2:0] ST_UPDATE = 3'd6;
    localparam logic [2:0] ST_ACK    = 3'd7;

    // Index width that never collapses to zero bits for tiny parameters.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cache_ctrl_nway_victim.sv
// Hit/invalid-way priority encoders and the per-set round-robin pointer file.
module cache_victim_sel
    import cache_ctrl_pkg::*;
#(
    parameter  int WAYS = 4,
    parameter  int SETS = 16,
    localparam int WW   = clog2_min1(WAYS),
    localparam int SW   = clog2_min1(SETS)
) (
    input  logic            clk,
    input  logic            not_reset,
    input  logic [SW-1:0]   i_set_idx,
    input  logic [WAYS-1:0] i_hit_vec,
    input  logic [WAYS-1:0] i_valid_vec,
    input  logic            i_rr_adv,
    output logic            o_hit_any,
    output logic [WW-1:0]   o_hit_way,
    output logic [WW-1:0]   o_victim_way,
    output logic            o_victim_from_ptr
);

    logic [WW-1:0] r_rr [SETS];
    logic          w_inv_any;
    logic [WW-1:0] w_inv_way;

    always_comb begin
        o_hit_any = 1'b0;
        o_hit_way = '0;
        w_inv_any = 1'b0;
        w_inv_way = '0;
        // Scan downwards so the lowest matching index wins.
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (i_hit_vec[i]) begin
                o_hit_any = 1'b1;
                o_hit_way = WW'(i);
            end
            if (!i_valid_vec[i]) begin
                w_inv_any = 1'b1;
                w_inv_way = WW'(i);
            end
        end
    end

    assign o_victim_from_ptr = !w_inv_any;
    assign o_victim_way      = w_inv_any ? w_inv_way : r_rr[i_set_idx];

    always_ff @(posedge clk or negedge not_reset) begin
        if (!not_reset) begin
            for (int s = 0; s < SETS; s++) r_rr[s] <= '0;
        end else if (i_rr_adv) begin
            r_rr[i_set_idx] <= r_rr[i_set_idx] + WW'(1);
        end
    end

endmodule

// File: rtl/cache_ctrl_nway.sv
// N-way set-associative cache control FSM; CACHE_CTRL_STATS_EN adds hit/miss/evict counters.
module cache_ctrl_nway
    import cache_ctrl_pkg::*;
#(
    parameter  int WAYS       = 4,
    parameter  int SETS       = 16,
    parameter  int BURST_LEN  = 4,
    parameter  int WRITE_BACK = 1,
    localparam int WW         = clog2_min1(WAYS),
    localparam int SW         = clog2_min1(SETS),
    localparam int BW         = clog2_min1(BURST_LEN)
) (
    input  logic            clk,
    input  logic            not_reset,
    input  logic            sys_rd,
    input  logic            sys_wr,
    input  logic [SW-1:0]   set_idx,
    input  logic [WAYS-1:0] hit_vec,
    input  logic [WAYS-1:0] valid_vec,
    input  logic [WAYS-1:0] dirty_vec,
    input  logic            ram_ack,
    output logic            ram_avalid,
    output logic            ram_rnw,
    output logic            ram_addr_victim,
    output logic [BW-1:0]   beat_idx,
    output logic [WW-1:0]   way_sel,
    output logic            data_src,
    output logic            data_we,
    output logic            tag_we,
    output logic            dirty_set,
    output logic            sys_ack
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [31:0]     stat_hits,
    output logic [31:0]     stat_misses,
    output logic [31:0]     stat_evicts
`endif
);

    logic [2:0]    r_state, w_nxt_state;
    logic          r_is_wr, w_nxt_is_wr;
    logic [SW-1:0] r_set, w_nxt_set;
    logic [WW-1:0] r_hit_way, w_nxt_hit_way;
    logic [WW-1:0] r_victim, w_nxt_victim;
    logic          r_vic_ptr, w_nxt_vic_ptr;
    logic [BW-1:0] r_beat, w_nxt_beat;
    logic          r_first, w_nxt_first;
    logic          w_last_beat, w_rr_adv;

    logic          w_hit_any, w_vic_ptr;
    logic [WW-1:0] w_hit_way, w_victim;

    logic          r_avalid, r_rnw, r_avict, r_src, r_we_whit, r_tag_we, r_dset, r_ack;
    logic [WW-1:0] r_way;
    logic          w_o_burst;

    cache_victim_sel #(.WAYS(WAYS), .SETS(SETS)) u_vsel (
        .clk               (clk),
        .not_reset         (not_reset),
        .i_set_idx         (r_set),
        .i_hit_vec         (hit_vec),
        .i_valid_vec       (valid_vec),
        .i_rr_adv          (w_rr_adv),
        .o_hit_any         (w_hit_any),
        .o_hit_way         (w_hit_way),
        .o_victim_way      (w_victim),
        .o_victim_from_ptr (w_vic_ptr)
    );

    assign w_last_beat = (r_beat == BW'(BURST_LEN - 1));

    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_is_wr   = r_is_wr;
        w_nxt_set     = r_set;
        w_nxt_hit_way = r_hit_way;
        w_nxt_victim  = r_victim;
        w_nxt_vic_ptr = r_vic_ptr;
        w_nxt_beat    = r_beat;
        w_nxt_first   = r_first;
        w_rr_adv      = 1'b0;
        case (r_state)
            ST_IDLE: if (sys_rd ^ sys_wr) begin
                w_nxt_state = ST_LOOKUP;
                w_nxt_is_wr = sys_wr;
                w_nxt_set   = set_idx;
                w_nxt_first = 1'b1;
            end
            ST_LOOKUP: begin
                w_nxt_first = 1'b0;
                if (w_hit_any) begin
                    w_nxt_hit_way = w_hit_way;
                    w_nxt_state   = r_is_wr ? ST_WHIT : ST_ACK;
                end else if (r_is_wr && (WRITE_BACK == 0)) begin
                    w_nxt_hit_way = '0;
                    w_nxt_state   = ST_WTHRU;
                end else begin
                    w_nxt_victim  = w_victim;
                    w_nxt_vic_ptr = w_vic_ptr;
                    w_nxt_beat    = '0;
                    if ((WRITE_BACK != 0) && valid_vec[w_victim] && dirty_vec[w_victim])
                        w_nxt_state = ST_EVICT;
                    else
                        w_nxt_state = ST_FILL;
                end
            end
            ST_WHIT:  w_nxt_state = (WRITE_BACK != 0) ? ST_ACK : ST_WTHRU;
            ST_WTHRU: if (ram_ack) w_nxt_state = ST_ACK;
            ST_EVICT: if (ram_ack) begin
                w_nxt_beat  = w_last_beat ? '0 : r_beat + BW'(1);
                w_nxt_state = w_last_beat ? ST_FILL : ST_EVICT;
            end
            ST_FILL: if (ram_ack) begin
                w_nxt_beat  = w_last_beat ? '0 : r_beat + BW'(1);
                w_nxt_state = w_last_beat ? ST_UPDATE : ST_FILL;
            end
            ST_UPDATE: begin
                w_rr_adv    = r_vic_ptr;
                w_nxt_state = ST_LOOKUP;
            end
            ST_ACK: if (!sys_rd && !sys_wr) w_nxt_state = ST_IDLE;
            default: w_nxt_state = ST_IDLE;
        endcase
    end

    assign w_o_burst = (w_nxt_state == ST_EVICT) || (w_nxt_state == ST_FILL) ||
                       (w_nxt_state == ST_UPDATE);

    always_ff @(posedge clk or negedge not_reset) begin
        if (!not_reset) begin
            r_state   <= ST_IDLE;
            r_is_wr   <= 1'b0;
            r_set     <= '0;
            r_hit_way <= '0;
            r_victim  <= '0;
            r_vic_ptr <= 1'b0;
            r_beat    <= '0;
            r_first   <= 1'b0;
            r_avalid  <= 1'b0;
            r_rnw     <= 1'b1;
            r_avict   <= 1'b0;
            r_src     <= 1'b0;
            r_we_whit <= 1'b0;
            r_tag_we  <= 1'b0;
            r_dset    <= 1'b0;
            r_ack     <= 1'b0;
            r_way     <= '0;
        end else begin
            r_state   <= w_nxt_state;
            r_is_wr   <= w_nxt_is_wr;
            r_set     <= w_nxt_set;
            r_hit_way <= w_nxt_hit_way;
            r_victim  <= w_nxt_victim;
            r_vic_ptr <= w_nxt_vic_ptr;
            r_beat    <= w_nxt_beat;
            r_first   <= w_nxt_first;
            r_avalid  <= (w_nxt_state == ST_WTHRU) || (w_nxt_state == ST_EVICT) ||
                         (w_nxt_state == ST_FILL);
            r_rnw     <= !((w_nxt_state == ST_WTHRU) || (w_nxt_state == ST_EVICT));
            r_avict   <= (w_nxt_state == ST_EVICT);
            r_src     <= (w_nxt_state == ST_FILL);
            r_we_whit <= (w_nxt_state == ST_WHIT);
            r_tag_we  <= (w_nxt_state == ST_UPDATE);
            r_dset    <= (w_nxt_state == ST_WHIT) && (WRITE_BACK != 0);
            r_ack     <= (w_nxt_state == ST_ACK);
            r_way     <= w_o_burst ? w_nxt_victim :
                         ((w_nxt_state == ST_WHIT) || (w_nxt_state == ST_WTHRU) ||
                          (w_nxt_state == ST_ACK)) ? w_nxt_hit_way : '0;
        end
    end

    assign ram_avalid      = r_avalid;
    assign ram_rnw         = r_rnw;
    assign ram_addr_victim = r_avict;
    assign beat_idx        = r_beat;
    assign way_sel         = r_way;
    assign data_src        = r_src;
    // Fill words land in the same cycle the RAM returns them, so the fill strobe follows ram_ack.
    assign data_we         = r_we_whit || ((r_state == ST_FILL) && ram_ack);
    assign tag_we          = r_tag_we;
    assign dirty_set       = r_dset;
    assign sys_ack         = r_ack;

`ifdef CACHE_CTRL_STATS_EN
    logic [31:0] r_hits, r_misses, r_evicts;

    always_ff @(posedge clk or negedge not_reset) begin
        if (!not_reset) begin
            r_hits   <= '0;
            r_misses <= '0;
            r_evicts <= '0;
        end else begin
            if ((r_state == ST_LOOKUP) && r_first) begin
                if (w_hit_any) r_hits   <= r_hits + 32'd1;
                else           r_misses <= r_misses + 32'd1;
            end
            if ((r_state == ST_LOOKUP) && (w_nxt_state == ST_EVICT))
                r_evicts <= r_evicts + 32'd1;
        end
    end

    assign stat_hits   = r_hits;
    assign stat_misses = r_misses;
    assign stat_evicts = r_evicts;
`endif

endmodule

// File: tb/tb_cache_ctrl_nway.sv
// Bench for cache_ctrl_nway: write-back and write-through instances, RAM responder, beat scoreboard.
module tb_cache_ctrl_nway;

    localparam logic [11:0] IDLE_OUTS = 12'h400;

    logic       clk, not_reset, sys_rd, sys_wr, ram_ack, sel_wt;
    logic [3:0] set_idx, hit_vec, valid_vec, dirty_vec;

    logic       wb_avalid, wb_rnw, wb_avict, wb_src, wb_we, wb_tag, wb_dset, wb_ack;
    logic       wt_avalid, wt_rnw, wt_avict, wt_src, wt_we, wt_tag, wt_dset, wt_ack;
    logic [1:0] wb_beat, wb_way, wt_beat, wt_way;
    logic       ack_wb, ack_wt;

    logic       m_avalid, m_rnw, m_avict, m_src, m_we, m_tag, m_dset, m_ack;
    logic [1:0] m_beat, m_way;

    logic [6:0] exp_q[$];
    int         errors, checks;
    int         o_lat, o_rises, o_tag, o_dset, o_whit;
    logic [1:0] o_ack_way;

    assign ack_wb = ram_ack & ~sel_wt;
    assign ack_wt = ram_ack & sel_wt;

    cache_ctrl_nway #(.WAYS(4), .SETS(16), .BURST_LEN(4), .WRITE_BACK(1)) u_wb (
        .clk(clk), .not_reset(not_reset), .sys_rd(sys_rd), .sys_wr(sys_wr),
        .set_idx(set_idx), .hit_vec(hit_vec), .valid_vec(valid_vec), .dirty_vec(dirty_vec),
        .ram_ack(ack_wb), .ram_avalid(wb_avalid), .ram_rnw(wb_rnw), .ram_addr_victim(wb_avict),
        .beat_idx(wb_beat), .way_sel(wb_way), .data_src(wb_src), .data_we(wb_we),
        .tag_we(wb_tag), .dirty_set(wb_dset), .sys_ack(wb_ack)
    );

    cache_ctrl_nway #(.WAYS(4), .SETS(16), .BURST_LEN(4), .WRITE_BACK(0)) u_wt (
        .clk(clk), .not_reset(not_reset), .sys_rd(sys_rd), .sys_wr(sys_wr),
        .set_idx(set_idx), .hit_vec(hit_vec), .valid_vec(valid_vec), .dirty_vec(dirty_vec),
        .ram_ack(ack_wt), .ram_avalid(wt_avalid), .ram_rnw(wt_rnw), .ram_addr_victim(wt_avict),
        .beat_idx(wt_beat), .way_sel(wt_way), .data_src(wt_src), .data_we(wt_we),
        .tag_we(wt_tag), .dirty_set(wt_dset), .sys_ack(wt_ack)
    );

    assign m_avalid = sel_wt ? wt_avalid : wb_avalid;
    assign m_rnw    = sel_wt ? wt_rnw    : wb_rnw;
    assign m_avict  = sel_wt ? wt_avict  : wb_avict;
    assign m_beat   = sel_wt ? wt_beat   : wb_beat;
    assign m_way    = sel_wt ? wt_way    : wb_way;
    assign m_src    = sel_wt ? wt_src    : wb_src;
    assign m_we     = sel_wt ? wt_we     : wb_we;
    assign m_tag    = sel_wt ? wt_tag    : wb_tag;
    assign m_dset   = sel_wt ? wt_dset   : wb_dset;
    assign m_ack    = sel_wt ? wt_ack    : wb_ack;

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] outs();
        return {m_avalid, m_rnw, m_avict, m_beat, m_way, m_src, m_we, m_tag, m_dset, m_ack};
    endfunction

    // Driver tasks
    task automatic do_reset();
        not_reset = 1'b0;
        sys_rd = 1'b0; sys_wr = 1'b0; ram_ack = 1'b0;
        set_idx = 4'd5; hit_vec = '0; valid_vec = 4'hF; dirty_vec = '0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) not_reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic push_burst(input logic [1:0] kind, input logic we, input logic [1:0] way);
        for (int b = 0; b < 4; b++) exp_q.push_back({kind, we, way, 2'(b)});
    endtask

    // Issues one request, plays RAM and tag array, and scoreboards every accepted beat.
    task automatic run_req(input logic rd, input logic wr, input logic rand_ack);
        logic       prev_av;
        logic [1:0] kind;
        logic [6:0] obs, expv;
        o_lat = -1; o_rises = 0; o_tag = 0; o_dset = 0; o_whit = 0; o_ack_way = '0;
        prev_av = 1'b0;
        sys_rd = rd; sys_wr = wr;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(posedge clk); #1;
            if (m_avalid && !prev_av) o_rises++;
            prev_av = m_avalid;
            ram_ack = m_avalid && (!rand_ack || ($urandom_range(0, 2) != 0));
            #1;
            if (m_tag) begin
                o_tag++;
                hit_vec = 4'b0001 << m_way;
                valid_vec[m_way] = 1'b1;
            end
            if (m_we && !m_src) o_whit++;
            if (m_dset) o_dset++;
            if (ram_ack && m_avalid) begin
                kind = !m_rnw ? (m_avict ? 2'd1 : 2'd3) : 2'd2;
                obs = {kind, m_we, m_way, m_beat};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got %b with empty expected queue", obs);
                end else begin
                    expv = exp_q.pop_front();
                    if (obs !== expv) begin
                        errors++;
                        $display("FAIL beat: got %b want %b", obs, expv);
                    end
                end
            end
            if (m_ack) begin
                o_lat = cyc;
                o_ack_way = m_way;
                break;
            end
        end
        ram_ack = 1'b0; sys_rd = 1'b0; sys_wr = 1'b0;
        checks++;
        if (o_lat < 0) begin errors++; $display("FAIL ack_timeout: no sys_ack in 200 cycles"); end
        @(posedge clk); #1;
        checks++;
        if (m_ack !== 1'b0) begin errors++; $display("FAIL ack_release: got %b want 0", m_ack); end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL beats_missing: %0d expected beats never seen", exp_q.size());
        end
        exp_q.delete();
    endtask

    // Scenario tasks
    task automatic test_reset();
        sel_wt = 1'b0;
        do_reset();
        checks++;
        if (outs() !== IDLE_OUTS) begin errors++; $display("FAIL reset_wb: got %h want %h", outs(), IDLE_OUTS); end
        sel_wt = 1'b1; #1;
        checks++;
        if (outs() !== IDLE_OUTS) begin errors++; $display("FAIL reset_wt: got %h want %h", outs(), IDLE_OUTS); end
        sel_wt = 1'b0;
    endtask

    task automatic test_read_hit();
        hit_vec = 4'b0100; valid_vec = 4'hF;
        run_req(1'b1, 1'b0, 1'b0);
        checks++; if (o_lat !== 2) begin errors++; $display("FAIL hit_latency: got %0d want 2", o_lat); end
        checks++; if (o_ack_way !== 2'd2) begin errors++; $display("FAIL hit_way: got %0d want 2", o_ack_way); end
        checks++; if (o_rises !== 0) begin errors++; $display("FAIL hit_no_ram: got %0d want 0", o_rises); end
    endtask

    task automatic test_clean_miss();
        for (int w = 0; w < 3; w++) begin
            hit_vec = '0; valid_vec = 4'hF; dirty_vec = '0;
            push_burst(2'd2, 1'b1, 2'(w));
            run_req(1'b1, 1'b0, w != 0);
            checks++; if (o_tag !== 1) begin errors++; $display("FAIL miss_tag_we: got %0d want 1", o_tag); end
            checks++; if (o_ack_way !== 2'(w)) begin errors++; $display("FAIL miss_way: got %0d want %0d", o_ack_way, w); end
            checks++; if (o_rises !== 1) begin errors++; $display("FAIL miss_avalid_rises: got %0d want 1", o_rises); end
            if (w == 0) begin
                checks++; if (o_lat !== 8) begin errors++; $display("FAIL miss_latency: got %0d want 8", o_lat); end
            end
        end
    endtask

    task automatic test_first_invalid();
        hit_vec = '0; valid_vec = 4'b1011; dirty_vec = '0;
        push_burst(2'd2, 1'b1, 2'd2);
        run_req(1'b1, 1'b0, 1'b1);
        checks++; if (o_ack_way !== 2'd2) begin errors++; $display("FAIL invalid_victim: got %0d want 2", o_ack_way); end
        hit_vec = '0; valid_vec = 4'hF;
        push_burst(2'd2, 1'b1, 2'd3);
        run_req(1'b1, 1'b0, 1'b1);
        checks++; if (o_ack_way !== 2'd3) begin errors++; $display("FAIL rr_after_invalid: got %0d want 3", o_ack_way); end
    endtask

    task automatic test_dirty_miss();
        hit_vec = '0; valid_vec = 4'hF; dirty_vec = 4'hF;
        push_burst(2'd1, 1'b0, 2'd0);
        push_burst(2'd2, 1'b1, 2'd0);
        run_req(1'b1, 1'b0, 1'b1);
        checks++; if (o_rises !== 1) begin errors++; $display("FAIL evict_fill_continuous: got %0d rises want 1", o_rises); end
        checks++; if (o_tag !== 1) begin errors++; $display("FAIL evict_tag_we: got %0d want 1", o_tag); end
        dirty_vec = '0;
    endtask

    task automatic test_write_hit_wb();
        hit_vec = 4'b0010; valid_vec = 4'hF;
        run_req(1'b0, 1'b1, 1'b0);
        checks++; if (o_lat !== 3) begin errors++; $display("FAIL wb_whit_latency: got %0d want 3", o_lat); end
        checks++; if (o_whit !== 1 || o_dset !== 1) begin errors++; $display("FAIL wb_whit_strobes: got we=%0d dset=%0d want 1 1", o_whit, o_dset); end
        checks++; if (o_ack_way !== 2'd1) begin errors++; $display("FAIL wb_whit_way: got %0d want 1", o_ack_way); end
    endtask

    task automatic test_write_through();
        sel_wt = 1'b1;
        do_reset();
        hit_vec = '0; valid_vec = 4'hF;
        exp_q.push_back({2'd3, 1'b0, 2'd0, 2'd0});
        run_req(1'b0, 1'b1, 1'b0);
        checks++; if (o_lat !== 3) begin errors++; $display("FAIL wt_miss_latency: got %0d want 3", o_lat); end
        checks++; if (o_tag !== 0 || o_whit !== 0) begin errors++; $display("FAIL wt_miss_no_alloc: got tag=%0d we=%0d want 0 0", o_tag, o_whit); end
        hit_vec = 4'b1000;
        exp_q.push_back({2'd3, 1'b0, 2'd3, 2'd0});
        run_req(1'b0, 1'b1, 1'b0);
        checks++; if (o_lat !== 4) begin errors++; $display("FAIL wt_hit_latency: got %0d want 4", o_lat); end
        checks++; if (o_whit !== 1 || o_dset !== 0) begin errors++; $display("FAIL wt_hit_strobes: got we=%0d dset=%0d want 1 0", o_whit, o_dset); end
        sel_wt = 1'b0;
    endtask

    task automatic test_both_high();
        do_reset();
        hit_vec = 4'b0001;
        sys_rd = 1'b1; sys_wr = 1'b1; ram_ack = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #2;
            checks++;
            if (outs() !== IDLE_OUTS) begin errors++; $display("FAIL both_high_idle: got %h want %h", outs(), IDLE_OUTS); end
        end
        sys_rd = 1'b0; sys_wr = 1'b0; ram_ack = 1'b0;
        run_req(1'b1, 1'b0, 1'b0);
        checks++; if (o_lat !== 2) begin errors++; $display("FAIL after_both_latency: got %0d want 2", o_lat); end
    endtask

    task automatic test_reset_mid_fill();
        logic seen;
        seen = 1'b0;
        do_reset();
        hit_vec = '0; valid_vec = 4'hF; dirty_vec = '0;
        sys_rd = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (m_avalid && m_rnw && (m_beat == 2'd2)) begin seen = 1'b1; break; end
            ram_ack = m_avalid;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL fill_beat2_timeout: FILL beat 2 never reached"); end
        not_reset = 1'b0; ram_ack = 1'b1; #1;
        checks++;
        if (outs() !== IDLE_OUTS) begin errors++; $display("FAIL reset_mid_fill: got %h want %h", outs(), IDLE_OUTS); end
        sys_rd = 1'b0; ram_ack = 1'b0;
        @(negedge clk) not_reset = 1'b1;
        @(posedge clk); #1;
        hit_vec = '0;
        push_burst(2'd2, 1'b1, 2'd0);
        run_req(1'b1, 1'b0, 1'b0);
        checks++; if (o_lat !== 8) begin errors++; $display("FAIL clean_after_reset: got %0d want 8", o_lat); end
    endtask

    // Sequencer and final report
    initial begin
        errors = 0; checks = 0;
        sel_wt = 1'b0;
        test_reset();
        test_read_hit();
        test_clean_miss();
        test_first_invalid();
        test_dirty_miss();
        test_write_hit_wb();
        test_write_through();
        test_both_high();
        test_reset_mid_fill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
